// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide)
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q;
    logic           neg_q;
    logic           special_q;
    logic [N-1:0]   mcand_q;
    logic [2*N-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   result_q;

    logic           accept;
    logic           is_div;
    logic           a_signed, b_signed;
    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic           div_zero, div_ovf, special;
    logic [N-1:0]   special_val;
    logic           neg_next;

    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [N:0]     div_trial;
    logic [2*N-1:0] div_next;

    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;
    logic [N-1:0]   fix_val;

    // Operand decode and magnitude/special-case detection at the accept edge
    always_comb begin
        accept   = start && ((state_q == IDLE) || (state_q == FIN));
        is_div   = op[2];
        a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = a_signed && a[N-1];
        b_neg    = b_signed && b[N-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && !op[0] && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_val = op[1] ? a : '1;
        end else begin
            special_val = op[1] ? '0 : a;
        end
        neg_next = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // One radix-2 iteration for each algorithm; acc holds {hi, lo}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
        mul_next  = {mul_sum, acc_q[N-1:1]};
        div_trial = {acc_q[2*N-1:N], acc_q[N-1]} - {1'b0, mcand_q};
        div_next  = div_trial[N] ? {acc_q[2*N-2:0], 1'b0}
                                 : {div_trial[N-1:0], acc_q[N-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
        rem_fix  = neg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
        if (special_q) begin
            fix_val = acc_q[N-1:0];
        end else if (op_q[2]) begin
            fix_val = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_val = (op_q[1:0] == 2'b00) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Special cases still pass through FIX so they finish one edge after accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FIN: begin
                if (accept) begin
                    state_d = special ? FIX : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= op;
            neg_q     <= neg_next;
            special_q <= special;
            mcand_q   <= is_div ? b_mag : a_mag;
            cnt_q     <= CW'(N - 1);
            if (special) begin
                acc_q <= {{N{1'b0}}, special_val};
            end else begin
                acc_q <= {{N{1'b0}}, (is_div ? a_mag : b_mag)};
            end
        end else if (state_q == CALC) begin
            acc_q <= op_q[2] ? div_next : mul_next;
            cnt_q <= cnt_q - 1'b1;
        end else if (state_q == FIX) begin
            result_q <= fix_val;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == FIN);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.N(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        logic        ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'd0, x});
        uy  = longint'({32'd0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (o)
            3'd0: begin p = 64'(ux * uy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux * uy); return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = 64'(sx / sy);
                return p[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                p = 64'(sx % sy);
                return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0)) return 1;
        if (((o == 3'd4) || (o == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Edges counted from the accept edge to the first edge after which done is seen
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        res = 32'hxxxx_xxxx;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd6,
                                3'd4, 3'd6, 3'd0, 3'd7};
    logic [31:0] d_a   [12] = '{32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_0005, 32'h0000_0005,
                                32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_0064};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h0000_0002, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0007};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005,
                                32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002};
    int          d_lat [12] = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 33};

    initial begin
        logic [31:0] res;
        int          lat;
        int          seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 12; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], res, lat);
            chk($sformatf("dir%0d_result", i), res, d_exp[i]);
            chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(d_lat[i]));
        end

        // Done is a single-cycle pulse and result holds afterwards
        @(posedge clk);
        #1;
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("result_hold", result, 32'h0000_0002);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op = 3'd4; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, res, lat);
        chk("post_abort_mul", res, 32'h0000_000C);
        chk("post_abort_lat", 32'(lat), 32'd33);

        // START held while busy with different operands must be ignored
        @(negedge clk);
        op = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        op = 3'd5; a = 32'd100; b = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        chk("held_start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        res = 32'hxxxx_xxxx;
        for (int k = 21; k <= 120; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
        chk("held_start_result", res, 32'd42);
        chk("held_start_lat", 32'(lat), 32'd33);

        // New op launched in the done cycle
        run_op(3'd5, 32'd100, 32'd3, res, lat);
        chk("b2b_result", res, 32'd33);
        chk("b2b_lat", 32'(lat), 32'd33);

        // Randomized sweep against the reference model
        for (int i = 0; i < 300; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 15)); rb = 32'($urandom_range(0, 15)); end
                3: rb = 32'($urandom_range(1, 300));
                4: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(ro, ra, rb, res, lat);
            chk($sformatf("rnd%0d_op%0d_%h_%h_result", i, ro, ra, rb), res, ref_res(ro, ra, rb));
            chk($sformatf("rnd%0d_op%0d_latency", i, ro), 32'(lat), 32'(ref_lat(ro, ra, rb)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
